// File: rtl/spi_slave_param.sv
// ============================================================================
// spi_slave_param: parametrised SPI slave (all four modes, multi-word bursts,
// MISO holding register with ready/load handshake).  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_slave_param #(
  parameter int DATA_W = 8,
  parameter int MODE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk_in,
  input  logic              mosi_in,
  input  logic              ss_n_in,
  input  logic [DATA_W-1:0] tx_data_in,
  input  logic              tx_load_in,
  output logic              tx_ready_out,
  output logic [DATA_W-1:0] rx_data_out,
  output logic              rx_valid_out,
  output logic              frame_err_out,
  output logic              busy_out,
  output logic              miso_out
);

  localparam logic             CPOL     = 1'((MODE >> 1) & 1);
  localparam logic             CPHA     = 1'(MODE & 1);
  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_UNARMED = 2'd0,
    ST_IDLE    = 2'd1,
    ST_FRAME   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic              sclk_s1, sclk_s2;
  logic              ss_s1, ss_s2;
  logic              mosi_s1, mosi_s2;
  logic [1:0]        warm;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] tx_hold;
  logic [DATA_W-1:0] tx_next;
  logic              skip_shift;

  logic in_frame, frame_start, frame_end;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic word_done, reload, load_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1 <= CPOL;
      sclk_s2 <= CPOL;
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      warm    <= 2'b00;
    end else begin
      sclk_s1 <= sclk_in;
      sclk_s2 <= sclk_s1;
      ss_s1   <= ss_n_in;
      ss_s2   <= ss_s1;
      mosi_s1 <= mosi_in;
      mosi_s2 <= mosi_s1;
      warm    <= {warm[0], 1'b1};
    end
  end

  assign lead_edge   = (sclk_s2 == CPOL) && (sclk_s1 != CPOL);
  assign trail_edge  = (sclk_s2 != CPOL) && (sclk_s1 == CPOL);
  assign in_frame    = (state == ST_FRAME);
  assign frame_start = (state == ST_IDLE) && ss_s2 && !ss_s1;
  assign frame_end   = in_frame && ss_s1 && !ss_s2;
  assign sample_edge = in_frame && (CPHA ? trail_edge : lead_edge);
  assign shift_edge  = in_frame && (CPHA ? lead_edge : trail_edge);
  assign word_done   = sample_edge && (bit_cnt == LAST_BIT);
  // A word finishing as ss_n rises still completes, but MISO is not reloaded.
  assign reload      = frame_start || (word_done && !frame_end);
  assign load_ok     = tx_load_in && tx_ready_out;
  assign tx_next     = !tx_ready_out ? tx_hold :
                       load_ok       ? tx_data_in : '0;

  // After reset the sync chain must see ss_n high on the real pin before a
  // falling edge may open a frame, so a frame already in progress is skipped.
  always_comb begin
    state_next = state;
    case (state)
      ST_UNARMED: if (warm[1] && ss_s1 && ss_s2) state_next = ST_IDLE;
      ST_IDLE:    if (frame_start) state_next = ST_FRAME;
      ST_FRAME:   if (frame_end) state_next = ST_IDLE;
      default:    state_next = ST_UNARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_UNARMED;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_out   <= '0;
      rx_valid_out  <= 1'b0;
      frame_err_out <= 1'b0;
      tx_ready_out  <= 1'b1;
      tx_hold       <= '0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      bit_cnt       <= '0;
      skip_shift    <= 1'b0;
    end else begin
      rx_valid_out  <= word_done;
      frame_err_out <= frame_end && !word_done && (bit_cnt != '0);

      if (word_done) rx_data_out <= {rx_shift[DATA_W-2:0], mosi_s2};

      if (frame_start || frame_end) bit_cnt <= '0;
      else if (sample_edge)         bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;

      if (frame_start)      rx_shift <= '0;
      else if (sample_edge) rx_shift <= {rx_shift[DATA_W-2:0], mosi_s2};

      if (frame_end)                      tx_shift <= '0;
      else if (reload)                    tx_shift <= tx_next;
      else if (shift_edge && !skip_shift) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};

      // The shift edge right after a (re)load must keep the new MSB on MISO.
      if (frame_start)     skip_shift <= CPHA;
      else if (word_done)  skip_shift <= 1'b1;
      else if (shift_edge) skip_shift <= 1'b0;

      if (reload && !tx_ready_out) begin
        tx_ready_out <= 1'b1;
      end else if (load_ok && !reload) begin
        tx_ready_out <= 1'b0;
        tx_hold      <= tx_data_in;
      end
    end
  end

  assign busy_out = !ss_s2;
  assign miso_out = tx_shift[DATA_W-1];

endmodule

`default_nettype wire
